// File: rtl/adder4_result_tx_if.sv
// Operand handshake between the adder datapath (master) and the serial result
// transmitter (slave).
interface adder4_result_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;

  modport master (output in_valid, output a, output b, output cin, input in_ready);
  modport slave  (input in_valid, input a, input b, input cin, output in_ready);
endinterface

// File: rtl/adder4_result_tx.sv
// Serial transmitter for the 4-bit adder sum: start, 5 data bits LSB-first,
// optional even parity (macro ADDER4_TX_PARITY_EN), stop. All outputs registered.
module adder4_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  adder4_result_tx_if.slave  in_if,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

`ifdef ADDER4_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  localparam logic [7:0] LAST    = 8'(CLKS_PER_BIT - 1);
  localparam bit         ONE_CLK = (CLKS_PER_BIT == 1);
  // frame_done is registered, so it is raised one cycle before the last stop cycle.
  localparam logic [7:0] DONE_AT = ONE_CLK ? 8'd0 : 8'(CLKS_PER_BIT - 2);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] sum_q, sum_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic [2:0] idx_nxt;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == LAST);
    idx_nxt = idx_q + 3'd1;

    if (state_q != IDLE) cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (in_if.in_valid && ready_q) begin
          sum_d   = {1'b0, in_if.a} + {1'b0, in_if.b} + {4'b0, in_if.cin};
          state_d = START;
          cnt_d   = 8'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = sum_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd4) begin
`ifdef ADDER4_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^sum_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
            done_d  = ONE_CLK;
`endif
          end else begin
            idx_d = idx_nxt;
            tx_d  = sum_q[idx_nxt];
          end
        end
      end
`ifdef ADDER4_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          done_d  = ONE_CLK;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          done_d = (cnt_q == DONE_AT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with <= only, so all flops sample the same pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      sum_q   <= 5'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_adder4_result_tx.sv
// Bench for adder4_result_tx: one DUT at CLKS_PER_BIT=4 and one at 1, scoreboard of
// expected sums decoded against the serial frame cycle by cycle.
module tb_adder4_result_tx;
`ifdef ADDER4_TX_PARITY_EN
  localparam int N_BITS = 8;
`else
  localparam int N_BITS = 7;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       cin = 1'b0;
  logic       sel = 1'b0;

  logic tx4, busy4, done4, tx1, busy1, done1;
  logic obs_tx, obs_busy, obs_ready, obs_done;

  int assertions = 0;
  int failures   = 0;
  logic [4:0] scb[$];

  always #5 clk = ~clk;

  adder4_result_tx_if if4 ();
  adder4_result_tx_if if1 ();

  assign if4.in_valid = in_valid & ~sel;
  assign if4.a        = a;
  assign if4.b        = b;
  assign if4.cin      = cin;
  assign if1.in_valid = in_valid & sel;
  assign if1.a        = a;
  assign if1.b        = b;
  assign if1.cin      = cin;

  adder4_result_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_if(if4), .tx(tx4), .busy(busy4), .frame_done(done4)
  );
  adder4_result_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_if(if1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  assign obs_tx    = sel ? tx1 : tx4;
  assign obs_busy  = sel ? busy1 : busy4;
  assign obs_ready = sel ? if1.in_ready : if4.in_ready;
  assign obs_done  = sel ? done1 : done4;

  // Waits for in_ready, presents operands for one accepting edge, records the sum.
  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    int guard = 0;
    logic [4:0] s;
    @(negedge clk);
    while (obs_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    assertions++;
    if (obs_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1 within 200 cycles", obs_ready);
    end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    s = {1'b0, ta} + {1'b0, tb} + {4'b0, tc};
    scb.push_back(s);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; checks cycles T+1 .. T+N*C and T+N*C+1.
  task automatic check_frame(input string name, input bit churn);
    logic [4:0] s;
    logic       exp_bits[8];
    logic       exp_tx;
    int         cpb;
    int         last;
    cpb  = sel ? 1 : 4;
    last = N_BITS * cpb;
    assertions++;
    if (scb.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard: queue empty, required one expected sum", name);
      return;
    end
    s = scb.pop_front();
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 5; i++) exp_bits[i+1] = s[i];
    exp_bits[6] = ^s;
    exp_bits[N_BITS-1] = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_tx = exp_bits[(k-1)/cpb];
      assertions++;
      if (obs_tx !== exp_tx) begin
        failures++;
        $display("FAIL %s_tx cycle T+%0d (s=%0d): tx=%b required %b", name, k, s, obs_tx, exp_tx);
      end
      assertions++;
      if ({obs_busy, obs_ready, obs_done} !== {1'b1, 1'b0, (k == last)}) begin
        failures++;
        $display("FAIL %s_status cycle T+%0d: busy/ready/done=%b%b%b required 10%b",
                 name, k, obs_busy, obs_ready, obs_done, (k == last));
      end
      if (churn) begin
        a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      end
    end
    @(negedge clk);
    assertions++;
    if ({obs_tx, obs_busy, obs_ready, obs_done} !== 4'b1010) begin
      failures++;
      $display("FAIL %s_idle cycle T+%0d: tx/busy/ready/done=%b%b%b%b required 1010",
               name, last + 1, obs_tx, obs_busy, obs_ready, obs_done);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    v = {tx4, busy4, if4.in_ready, done4, tx1, busy1, if1.in_ready, done1};
    assertions++;
    if (v !== 8'hAA) begin
      failures++;
      $display("FAIL reset_held: outputs=%b required 10101010", v);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v = {tx4, busy4, if4.in_ready, done4, tx1, busy1, if1.in_ready, done1};
      assertions++;
      if (v !== 8'hAA) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: outputs=%b required 10101010", i, v);
      end
    end
  endtask

  task automatic test_frames();
    sel = 1'b0;
    send(4'd9, 4'd8, 1'b0);
    check_frame("s17", 1'b0);
    send(4'd15, 4'd15, 1'b1);
    check_frame("s31", 1'b0);
    send(4'd6, 4'd5, 1'b1);
    check_frame("s12", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] s;
    sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      assertions++;
      if (obs_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready frame %0d: in_ready=%b required 1", f, obs_ready);
      end
      s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      scb.push_back(s);
      check_frame($sformatf("b2b%0d", f), 1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    send(4'd9, 4'd8, 1'b0);
    repeat (13) @(negedge clk);
    assertions++;
    if ({obs_tx, obs_busy} !== 2'b01) begin
      failures++;
      $display("FAIL midrst_pre: tx/busy=%b%b required 01 in data bit 2", obs_tx, obs_busy);
    end
    rst = 1'b1;
    #1;
    assertions++;
    if ({obs_tx, obs_busy, obs_ready, obs_done} !== 4'b1010) begin
      failures++;
      $display("FAIL midrst_abort: tx/busy/ready/done=%b%b%b%b required 1010",
               obs_tx, obs_busy, obs_ready, obs_done);
    end
    scb.delete();
    @(negedge clk);
    rst = 1'b0;
    send(4'd1, 4'd2, 1'b0);
    check_frame("after_rst", 1'b0);
  endtask

  task automatic test_one_clk_per_bit();
    sel = 1'b1;
    @(negedge clk);
    send(4'd0, 4'd0, 1'b0);
    check_frame("cpb1_s0", 1'b0);
    send(4'd10, 4'd3, 1'b1);
    check_frame("cpb1_s14", 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_one_clk_per_bit();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/adder4_result_tx.md
# adder4_result_tx

Serial result transmitter for the 4-bit adder tile. It accepts one pair of operands through a valid/ready handshake and computes the 5-bit sum (4-bit sum plus carry-out). It then shifts the sum out LSB-first on a single output pin as a UART-style frame: start bit, data bits, optional parity, stop bit. It sits between the adder datapath and a dedicated `uo_out` pin, so the result can be read off-chip with one wire.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operands `a`, `b` and `cin` are valid this cycle.
- `in_ready` out 1: the block can accept operands.
- `a` in 4: operand A.
- `b` in 4: operand B.
- `cin` in 1: carry-in.
- `tx` out 1: serial output; idle level is 1.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- Sum is `s[4:0] = a + b + cin`, zero-extended to 5 bits; range 0..31; no overflow is possible.
- Handshake:
  - Transfer occurs on a rising edge where `in_valid && in_ready`.
  - `s` is latched into a 5-bit shift register on that edge.
  - `a`, `b` and `cin` are don't-care at all other times.
- `in_ready` is 1 only in IDLE. `in_valid` asserted outside IDLE is ignored and nothing is queued.
- FSM states and transitions:
  - IDLE: `tx`=1, `busy`=0. Goes to START on a transfer.
  - START: `tx`=0. Goes to DATA.
  - DATA: `tx`=`s[i]` for i=0..4, LSB first. After bit 4 goes to PARITY if enabled, otherwise to STOP.
  - PARITY: `tx` = even parity, i.e. `^s`. Goes to STOP.
  - STOP: `tx`=1. Goes to IDLE.
- Every non-IDLE state (each data bit individually) lasts exactly `CLKS_PER_BIT` cycles, timed by a bit-cycle counter. A 3-bit index counter selects the data bit.
- All outputs are registered.
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `frame_done`=0, FSM=IDLE, counters=0.
- Reset mid-frame aborts the frame immediately (asynchronously): `tx` returns to 1 with no partial stop bit, and the in-flight sum is discarded.

## Timing
- Let edge T be the accepting edge.
- From T+1, `tx`=0, `busy`=1 and `in_ready`=0.
- Frame length N = 7 bits without parity, 8 bits with parity. The frame occupies cycles T+1 .. T+N·`CLKS_PER_BIT`.
- `frame_done`=1 during cycle T+N·`CLKS_PER_BIT` only, which is the last stop-bit cycle.
- The next cycle is IDLE: `busy`=0, `in_ready`=1, `tx`=1.
- The earliest next acceptance is that cycle, so there is at least 1 idle cycle between back-to-back frames.
- With `CLKS_PER_BIT`=1, each bit lasts exactly 1 cycle. There is no off-by-one: the counter compares against `CLKS_PER_BIT-1`.
- `frame_done` and the START of the next frame never coincide.

## Configuration
- Macro `ADDER4_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in, and the frame is 8 bits with the even-parity bit (XOR of `s[4:0]`) before the stop bit.
  - Undefined: there is no PARITY state or parity logic, and the frame is 7 bits (DATA goes directly to STOP).
- No other behaviour differs between the two builds.

## Test plan
- Reset, then idle: `tx`=1, `busy`=0, `in_ready`=1 and `frame_done`=0 held for 20 cycles.
- `CLKS_PER_BIT`=4, no parity, `a`=9, `b`=8, `cin`=0 (s=17=10001b):
  - `tx` per bit is 0,1,0,0,0,1,1, each held 4 cycles.
  - `frame_done` is high at T+28.
  - `in_ready` returns to 1 at T+29.
- Parity build, `a`=15, `b`=15, `cin`=1 (s=31):
  - `tx` per bit is 0,1,1,1,1,1,1,1.
  - Parity bit is 1; frame is 32 cycles.
- Parity build, `a`=9, `b`=8, `cin`=0: parity bit is 0.
- `in_valid` held high continuously with changing operands: only the operands present on the accepting edges are sent, and consecutive frames are separated by exactly 1 idle cycle.
- Reset at the 3rd data bit: `tx`=1 and `busy`=0 immediately. After release, `a`=1, `b`=2, `cin`=0 sends a clean frame with s=3.
- `CLKS_PER_BIT`=1, `a`=0, `b`=0, `cin`=0 (s=0): frame is 0,0,0,0,0,0,1 over 7 cycles, with `frame_done` at T+7.
